// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode constants, issue-FSM state type and opcode helpers
//               shared by the ALU issue controller and its decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] c_op_and = 4'd0;
  localparam logic [3:0] c_op_or  = 4'd1;
  localparam logic [3:0] c_op_neg = 4'd2;
  localparam logic [3:0] c_op_not = 4'd3;
  localparam logic [3:0] c_op_sub = 4'd4;
  localparam logic [3:0] c_op_add = 4'd5;
  localparam logic [3:0] c_op_mul = 4'd6;
  localparam logic [3:0] c_op_ror = 4'd7;
  localparam logic [3:0] c_op_div = 4'd8;
  localparam logic [3:0] c_op_shr = 4'd9;
  localparam logic [3:0] c_op_shl = 4'd10;

  localparam int c_num_ops = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == c_op_mul) || (op == c_op_div);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Combinational 4-bit opcode to 11-bit one-hot ALU select,
//               plus a flag for the unused opcodes 11..15.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [3:0]           op,
  output logic [c_num_ops-1:0] onehot,
  output logic                 illegal
);

  // Bit i of the one-hot vector corresponds to opcode i.
  for (genvar i = 0; i < c_num_ops; i++) begin : g_onehot
    assign onehot[i] = (op == 4'(i));
  end

  assign illegal = (op >= 4'(c_num_ops));

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Accepts one ALU request, drives operands and a one-hot select
//               for the op's duration, then captures the result into Z.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned MULDIV_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_rb,
  output logic [31:0] alu_ry,
  output logic        op_and,
  output logic        op_or,
  output logic        op_neg,
  output logic        op_not,
  output logic        op_sub,
  output logic        op_add,
  output logic        op_mul,
  output logic        op_ror,
  output logic        op_div,
  output logic        op_shr,
  output logic        op_shl,
  input  logic [31:0] alu_lo,
  input  logic [31:0] alu_hi,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] z_lo,
  output logic [31:0] z_hi,
  output logic        err_op,
  output logic        err_div0
);

  localparam bit         c_has_wait  = (MULDIV_WAIT != 0);
  localparam logic [3:0] c_wait_init = 4'(MULDIV_WAIT - 1);

  logic [c_num_ops-1:0] w_dec_onehot;
  logic                 w_dec_illegal;
  logic                 w_req_div0;

  state_t               r_state;
  logic [3:0]           r_op;
  logic                 r_illegal;
  logic                 r_div0;
  logic [3:0]           r_cnt;
  logic [c_num_ops-1:0] r_op_lines;

  alu_op_decode u_op_decode (
    .op      (req_op),
    .onehot  (w_dec_onehot),
    .illegal (w_dec_illegal)
  );

  assign w_req_div0 = (req_op == c_op_div) && (req_b == 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_op       <= 4'd0;
      r_illegal  <= 1'b0;
      r_div0     <= 1'b0;
      r_cnt      <= 4'd0;
      r_op_lines <= '0;
      req_ready  <= 1'b1;
      alu_rb     <= 32'd0;
      alu_ry     <= 32'd0;
      res_valid  <= 1'b0;
      z_lo       <= 32'd0;
      z_hi       <= 32'd0;
      err_op     <= 1'b0;
      err_div0   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            alu_rb     <= req_a;
            alu_ry     <= req_b;
            r_op       <= req_op;
            r_illegal  <= w_dec_illegal;
            r_div0     <= w_req_div0;
            // Divide-by-zero never selects the divider.
            r_op_lines <= w_req_div0 ? '0 : w_dec_onehot;
            err_op     <= 1'b0;
            err_div0   <= 1'b0;
            req_ready  <= 1'b0;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_illegal || r_div0) begin
            z_lo       <= 32'd0;
            z_hi       <= 32'd0;
            err_op     <= r_illegal;
            err_div0   <= r_div0;
            r_op_lines <= '0;
            res_valid  <= 1'b1;
            r_state    <= ST_DONE;
          end else if (is_muldiv(r_op) && c_has_wait) begin
            r_cnt   <= c_wait_init;
            r_state <= ST_WAIT;
          end else begin
            // Only multicycle ops produce a meaningful high word.
            z_lo <= alu_lo;
            if (is_muldiv(r_op)) begin
              z_hi <= alu_hi;
            end
            r_op_lines <= '0;
            res_valid  <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            z_lo       <= alu_lo;
            z_hi       <= alu_hi;
            r_op_lines <= '0;
            res_valid  <= 1'b1;
            r_state    <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            req_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign op_and = r_op_lines[c_op_and];
  assign op_or  = r_op_lines[c_op_or];
  assign op_neg = r_op_lines[c_op_neg];
  assign op_not = r_op_lines[c_op_not];
  assign op_sub = r_op_lines[c_op_sub];
  assign op_add = r_op_lines[c_op_add];
  assign op_mul = r_op_lines[c_op_mul];
  assign op_ror = r_op_lines[c_op_ror];
  assign op_div = r_op_lines[c_op_div];
  assign op_shr = r_op_lines[c_op_shr];
  assign op_shl = r_op_lines[c_op_shl];

endmodule
`default_nettype wire
